multicycle_ctrl_hs: RTL and testbench

- Parametrised multicycle control unit for the RV32I-subset core. Drives the existing datapath's control inputs and the data-memory strobes.
- Extends the fixed five-state sequencer with:
  - variable-latency data-memory handshake (dReady) and an optional timeout;
  - an optional MEM-skip for non-memory instructions;
  - BNE support;
  - illegal-instruction trap;
  - retired-instruction counter.

---
 rtl/multicycle_ctrl_hs_if.sv | 32 +++
 rtl/multicycle_ctrl_hs.sv | 154 +++++++++++++++
 tb/tb_multicycle_ctrl_hs.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_hs_if.sv
// Control-unit bus: instruction/flag/memory-acknowledge inputs in,
// datapath control strobes and status out. The control unit is the master.
interface multicycle_ctrl_hs_if #(
  parameter int CNT_W = 32
);
  logic [31:0]      instr;
  logic             Zero;
  logic             dReady;
  logic [3:0]       ALUCtrl;
  logic             ALUSrc;
  logic             MemToReg;
  logic             RegWrite;
  logic             loadPC;
  logic             PCSrc;
  logic             MemRead;
  logic             MemWrite;
  logic [2:0]       state;
  logic             trap;
  logic [CNT_W-1:0] retired;

  modport master (
    input  instr, Zero, dReady,
    output ALUCtrl, ALUSrc, MemToReg, RegWrite, loadPC, PCSrc,
           MemRead, MemWrite, state, trap, retired
  );

  modport slave (
    output instr, Zero, dReady,
    input  ALUCtrl, ALUSrc, MemToReg, RegWrite, loadPC, PCSrc,
           MemRead, MemWrite, state, trap, retired
  );
endinterface

// File: rtl/multicycle_ctrl_hs.sv
// Multicycle control unit for the RV32I-subset core: IF/ID/EX/MEM/WB sequencer
// with a variable-latency data-memory handshake, optional MEM timeout,
// optional MEM skip for non-memory instructions, BEQ/BNE, an illegal-instruction
// trap and a retired-instruction counter.
module multicycle_ctrl_hs #(
  parameter int SKIP_MEM    = 1,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input logic                  clk,
  input logic                  rst,
  multicycle_ctrl_hs_if.master bus
);

  typedef enum logic [2:0] {
    S_IF   = 3'b000,
    S_ID   = 3'b001,
    S_EX   = 3'b010,
    S_MEM  = 3'b011,
    S_WB   = 3'b100,
    S_TRAP = 3'b101
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_LT  = 4'b0111;
  localparam logic [3:0] ALU_SRL = 4'b1000;
  localparam logic [3:0] ALU_SLL = 4'b1001;
  localparam logic [3:0] ALU_SRA = 4'b1010;
  localparam logic [3:0] ALU_XOR = 4'b1101;

  // The wait counter only has to reach MEM_TIMEOUT-1; with the timeout
  // disabled it is a harmless 1-bit wrapping counter.
  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] TIMEOUT_LAST =
    WAIT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_q;
  logic [CNT_W-1:0]  retired_q;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       is_lw, is_sw, is_beq, is_bne, is_ialu, is_ralu;
  logic       is_mem, legal;
  logic [3:0] alu_ctrl;

  logic unused_fields;

  assign opcode = bus.instr[6:0];
  assign funct3 = bus.instr[14:12];
  assign funct7 = bus.instr[31:25];

  // Register numbers are consumed by the datapath, not by the controller.
  assign unused_fields = ^{bus.instr[24:15], bus.instr[11:7]};

  // Instruction classification; anything not matched here is illegal.
  always_comb begin
    is_lw   = (opcode == OP_LOAD)  && (funct3 == 3'b010);
    is_sw   = (opcode == OP_STORE) && (funct3 == 3'b010);
    is_beq  = (opcode == OP_BRANCH) && (funct3 == 3'b000);
    is_bne  = (opcode == OP_BRANCH) && (funct3 == 3'b001);
    is_ialu = (opcode == OP_IMM) &&
              ((funct3 != 3'b101) || (funct7 == 7'b0000000) || (funct7 == 7'b0100000));
    is_ralu = (opcode == OP_REG) &&
              (((funct7 == 7'b0000000) && (funct3 != 3'b011)) ||
               ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101))));
    is_mem  = is_lw || is_sw;
    legal   = is_mem || is_beq || is_bne || is_ialu || is_ralu;
  end

  // ALU operation select; SLTI and SLTIU both use the LT operation.
  always_comb begin
    alu_ctrl = ALU_AND;
    if (is_mem) begin
      alu_ctrl = ALU_ADD;
    end else if (is_beq || is_bne) begin
      alu_ctrl = ALU_SUB;
    end else if (is_ialu || is_ralu) begin
      case (funct3)
        3'b000:  alu_ctrl = (is_ralu && funct7[5]) ? ALU_SUB : ALU_ADD;
        3'b001:  alu_ctrl = ALU_SLL;
        3'b010:  alu_ctrl = ALU_LT;
        3'b011:  alu_ctrl = ALU_LT;
        3'b100:  alu_ctrl = ALU_XOR;
        3'b101:  alu_ctrl = funct7[5] ? ALU_SRA : ALU_SRL;
        3'b110:  alu_ctrl = ALU_OR;
        default: alu_ctrl = ALU_AND;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IF;
    else     state_q <= state_d;
  end

  // Next-state logic; dReady takes priority over the timeout in the last MEM cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IF:   state_d = S_ID;
      S_ID:   state_d = legal ? S_EX : S_TRAP;
      S_EX:   state_d = (is_mem || (SKIP_MEM == 0)) ? S_MEM : S_WB;
      S_MEM: begin
        if (!is_mem || bus.dReady)
          state_d = S_WB;
        else if ((MEM_TIMEOUT > 0) && (wait_q == TIMEOUT_LAST))
          state_d = S_TRAP;
        else
          state_d = S_MEM;
      end
      S_WB:   state_d = S_IF;
      S_TRAP: state_d = S_TRAP;
      default: state_d = S_IF;
    endcase
  end

  // MEM wait counter: zero outside MEM, so it is clear on every MEM entry.
  always_ff @(posedge clk) begin
    if (rst)                  wait_q <= '0;
    else if (state_q != S_MEM) wait_q <= '0;
    else if (!bus.dReady)     wait_q <= wait_q + WAIT_W'(1);
  end

  // Retired-instruction counter, bumped once per WB cycle and wrapping.
  always_ff @(posedge clk) begin
    if (rst)                  retired_q <= '0;
    else if (state_q == S_WB) retired_q <= retired_q + CNT_W'(1);
  end

  assign bus.state    = state_q;
  assign bus.trap     = (state_q == S_TRAP);
  assign bus.retired  = retired_q;
  assign bus.MemRead  = (state_q == S_MEM) && is_lw;
  assign bus.MemWrite = (state_q == S_MEM) && is_sw;
  assign bus.loadPC   = (state_q == S_WB);
  assign bus.RegWrite = (state_q == S_WB) && (is_lw || is_ialu || is_ralu);
  assign bus.ALUCtrl  = alu_ctrl;
  assign bus.ALUSrc   = is_lw || is_sw || is_ialu;
  assign bus.MemToReg = is_lw;
  assign bus.PCSrc    = (is_beq && bus.Zero) || (is_bne && !bus.Zero);

endmodule

// File: tb/tb_multicycle_ctrl_hs.sv
// Testbench for multicycle_ctrl_hs: two configurations (skip/timeout/4-bit
// counter, and pass-through-MEM/no-timeout/32-bit counter), each exercised in
// turn while the other is held in reset, against an instruction-level model.
module tb_multicycle_ctrl_hs;

  localparam int ST_IF = 0, ST_ID = 1, ST_EX = 2, ST_MEM = 3, ST_WB = 4, ST_TRAP = 5;

  localparam logic [3:0] A_AND = 4'b0000, A_OR = 4'b0001, A_ADD = 4'b0010,
                         A_SUB = 4'b0110, A_LT = 4'b0111, A_SRL = 4'b1000,
                         A_SLL = 4'b1001, A_SRA = 4'b1010, A_XOR = 4'b1101;

  typedef enum int {C_LW, C_SW, C_BEQ, C_BNE, C_ALUI, C_ALUR, C_ILL} cls_t;

  logic        clk = 1'b0;
  logic        rstA = 1'b1;
  logic        rstB = 1'b1;
  logic        sel = 1'b0;
  logic [31:0] instr = 32'h0;
  logic        zero = 1'b0;
  logic        dReady = 1'b0;

  int          nCompared = 0;
  int          nMismatched = 0;
  int          mSkip = 1;
  int          mTimeout = 4;
  logic [31:0] mMask = 32'hF;
  int          modelRetired = 0;

  multicycle_ctrl_hs_if #(.CNT_W(4))  ifA ();
  multicycle_ctrl_hs_if #(.CNT_W(32)) ifB ();

  assign ifA.instr  = instr;
  assign ifA.Zero   = zero;
  assign ifA.dReady = dReady;
  assign ifB.instr  = instr;
  assign ifB.Zero   = zero;
  assign ifB.dReady = dReady;

  multicycle_ctrl_hs #(.SKIP_MEM(1), .MEM_TIMEOUT(4), .CNT_W(4)) dutA (
    .clk(clk), .rst(rstA), .bus(ifA.master)
  );

  multicycle_ctrl_hs #(.SKIP_MEM(0), .MEM_TIMEOUT(0), .CNT_W(32)) dutB (
    .clk(clk), .rst(rstB), .bus(ifB.master)
  );

  logic [2:0]  oState;
  logic [3:0]  oAlu;
  logic        oAluSrc, oMemToReg, oRegWrite, oLoadPC, oPCSrc, oMemRead, oMemWrite, oTrap;
  logic [31:0] oRetired;

  // Observe whichever DUT is currently active.
  always_comb begin
    if (sel) begin
      oState = ifB.state;  oAlu = ifB.ALUCtrl;  oAluSrc = ifB.ALUSrc;
      oMemToReg = ifB.MemToReg;  oRegWrite = ifB.RegWrite;  oLoadPC = ifB.loadPC;
      oPCSrc = ifB.PCSrc;  oMemRead = ifB.MemRead;  oMemWrite = ifB.MemWrite;
      oTrap = ifB.trap;  oRetired = ifB.retired;
    end else begin
      oState = ifA.state;  oAlu = ifA.ALUCtrl;  oAluSrc = ifA.ALUSrc;
      oMemToReg = ifA.MemToReg;  oRegWrite = ifA.RegWrite;  oLoadPC = ifA.loadPC;
      oPCSrc = ifA.PCSrc;  oMemRead = ifA.MemRead;  oMemWrite = ifA.MemWrite;
      oTrap = ifA.trap;  oRetired = {28'd0, ifA.retired};
    end
  end

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCompared++;
    if (obs !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic setRst(input logic v);
    if (sel) rstB = v;
    else     rstA = v;
  endtask

  // Instruction class and ALU code straight from the ISA subset tables.
  function automatic void classify(input logic [31:0] ins, output cls_t c, output logic [3:0] alu);
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    op = ins[6:0];
    f3 = ins[14:12];
    f7 = ins[31:25];
    c = C_ILL;
    alu = A_AND;
    case (op)
      7'b0000011: if (f3 == 3'b010) begin c = C_LW; alu = A_ADD; end
      7'b0100011: if (f3 == 3'b010) begin c = C_SW; alu = A_ADD; end
      7'b1100011: begin
        if (f3 == 3'b000)      begin c = C_BEQ; alu = A_SUB; end
        else if (f3 == 3'b001) begin c = C_BNE; alu = A_SUB; end
      end
      7'b0010011: begin
        c = C_ALUI;
        case (f3)
          3'b000: alu = A_ADD;
          3'b001: alu = A_SLL;
          3'b010: alu = A_LT;
          3'b011: alu = A_LT;
          3'b100: alu = A_XOR;
          3'b110: alu = A_OR;
          3'b111: alu = A_AND;
          default: begin
            if (f7 == 7'b0000000)      alu = A_SRL;
            else if (f7 == 7'b0100000) alu = A_SRA;
            else                       c = C_ILL;
          end
        endcase
      end
      7'b0110011: begin
        c = C_ALUR;
        case ({f7, f3})
          10'b0000000_000: alu = A_ADD;
          10'b0100000_000: alu = A_SUB;
          10'b0000000_001: alu = A_SLL;
          10'b0000000_101: alu = A_SRL;
          10'b0100000_101: alu = A_SRA;
          10'b0000000_010: alu = A_LT;
          10'b0000000_100: alu = A_XOR;
          10'b0000000_110: alu = A_OR;
          10'b0000000_111: alu = A_AND;
          default:         c = C_ILL;
        endcase
      end
      default: c = C_ILL;
    endcase
    if (c == C_ILL) alu = A_AND;
  endfunction

  function automatic logic [31:0] genLegal();
    logic [31:0] w;
    int k;
    w = $urandom;
    k = $urandom_range(0, 5);
    case (k)
      0: begin w[6:0] = 7'b0000011; w[14:12] = 3'b010; end
      1: begin w[6:0] = 7'b0100011; w[14:12] = 3'b010; end
      2: begin w[6:0] = 7'b1100011; w[14:12] = {2'b00, 1'($urandom_range(0, 1))}; end
      3: begin
        w[6:0] = 7'b0010011;
        if (w[14:12] == 3'b101)
          w[31:25] = ($urandom_range(0, 1) == 1) ? 7'b0100000 : 7'b0000000;
      end
      default: begin
        w[6:0] = 7'b0110011;
        case ($urandom_range(0, 8))
          0: {w[31:25], w[14:12]} = 10'b0000000_000;
          1: {w[31:25], w[14:12]} = 10'b0100000_000;
          2: {w[31:25], w[14:12]} = 10'b0000000_001;
          3: {w[31:25], w[14:12]} = 10'b0000000_101;
          4: {w[31:25], w[14:12]} = 10'b0100000_101;
          5: {w[31:25], w[14:12]} = 10'b0000000_010;
          6: {w[31:25], w[14:12]} = 10'b0000000_111;
          7: {w[31:25], w[14:12]} = 10'b0000000_110;
          default: {w[31:25], w[14:12]} = 10'b0000000_100;
        endcase
      end
    endcase
    return w;
  endfunction

  function automatic logic [31:0] genIllegal();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 3))
      0: w[6:0] = 7'b1111111;
      1: begin w[6:0] = 7'b0000011; w[14:12] = 3'b000; end
      2: begin w[6:0] = 7'b0010011; w[14:12] = 3'b101; w[31:25] = 7'b0000001; end
      default: begin w[6:0] = 7'b0110011; w[31:25] = 7'b0000001; end
    endcase
    return w;
  endfunction

  // Every output of the active DUT against what the current state and instruction imply.
  task automatic checkCycle(input int st, input cls_t c, input logic [3:0] alu, input logic z);
    checkOutput("state",    32'(oState),    32'(st));
    checkOutput("trap",     32'(oTrap),     32'(st == ST_TRAP));
    checkOutput("MemRead",  32'(oMemRead),  32'(st == ST_MEM && c == C_LW));
    checkOutput("MemWrite", 32'(oMemWrite), 32'(st == ST_MEM && c == C_SW));
    checkOutput("loadPC",   32'(oLoadPC),   32'(st == ST_WB));
    checkOutput("RegWrite", 32'(oRegWrite), 32'(st == ST_WB && (c == C_LW || c == C_ALUI || c == C_ALUR)));
    checkOutput("PCSrc",    32'(oPCSrc),    32'((c == C_BEQ && z) || (c == C_BNE && !z)));
    checkOutput("ALUCtrl",  32'(oAlu),      32'(alu));
    checkOutput("ALUSrc",   32'(oAluSrc),   32'(c == C_LW || c == C_SW || c == C_ALUI));
    checkOutput("MemToReg", 32'(oMemToReg), 32'(c == C_LW));
    checkOutput("retired",  oRetired,       32'(modelRetired) & mMask);
  endtask

  task automatic applyReset();
    setRst(1'b1);
    repeat (2) begin
      @(negedge clk);
      checkOutput("rst_state",   32'(oState),   32'(ST_IF));
      checkOutput("rst_trap",    32'(oTrap),    32'd0);
      checkOutput("rst_retired", oRetired,      32'd0);
      checkOutput("rst_strobes", 32'({oMemRead, oMemWrite, oRegWrite, oLoadPC}), 32'd0);
    end
    setRst(1'b0);
    modelRetired = 0;
  endtask

  // Run one instruction from IF. zMode 0/1 fixes Zero, 2 randomises it.
  // readyAt is the MEM cycle (1-based) with dReady high, 0 = never.
  // abortMem > 0 asserts rst in that MEM cycle instead of finishing.
  task automatic applyStimulus(input logic [31:0] ins, input int zMode, input int readyAt, input int abortMem);
    cls_t c;
    logic [3:0] alu;
    int seq[$];
    int nMem;
    int memIdx;
    bit completes;
    bit trapped;
    classify(ins, c, alu);
    trapped = 0;
    seq.push_back(ST_IF);
    seq.push_back(ST_ID);
    if (c == C_ILL) begin
      trapped = 1;
      repeat (11) seq.push_back(ST_TRAP);
    end else begin
      seq.push_back(ST_EX);
      if (c == C_LW || c == C_SW) begin
        completes = (readyAt > 0) && (mTimeout == 0 || readyAt <= mTimeout);
        nMem = completes ? readyAt : mTimeout;
        repeat (nMem) seq.push_back(ST_MEM);
        if (completes) seq.push_back(ST_WB);
        else begin
          trapped = 1;
          repeat (11) seq.push_back(ST_TRAP);
        end
      end else begin
        if (mSkip == 0) seq.push_back(ST_MEM);
        seq.push_back(ST_WB);
      end
    end

    instr = ins;
    memIdx = 0;
    foreach (seq[k]) begin
      if (seq[k] == ST_MEM) memIdx++;
      zero = (zMode == 2) ? 1'($urandom_range(0, 1)) : 1'(zMode);
      if (seq[k] == ST_MEM && (c == C_LW || c == C_SW))
        dReady = 1'(memIdx == readyAt);
      else
        dReady = 1'($urandom_range(0, 1));
      if (abortMem > 0 && seq[k] == ST_MEM && memIdx == abortMem) begin
        setRst(1'b1);
        @(negedge clk);
        checkOutput("abort_state",   32'(oState), 32'(ST_IF));
        checkOutput("abort_trap",    32'(oTrap),  32'd0);
        checkOutput("abort_retired", oRetired,    32'd0);
        checkOutput("abort_memrd",   32'(oMemRead), 32'd0);
        setRst(1'b0);
        modelRetired = 0;
        return;
      end
      #1;
      checkCycle(seq[k], c, alu, zero);
      if (seq[k] == ST_WB) modelRetired++;
      @(negedge clk);
    end
    if (trapped) applyReset();
  endtask

  initial begin
    logic [31:0] w;

    // Configuration A: SKIP_MEM=1, MEM_TIMEOUT=4, CNT_W=4.
    sel = 1'b0; mSkip = 1; mTimeout = 4; mMask = 32'hF;
    applyReset();
    repeat (3) applyStimulus(32'h00500093, 2, 0, 0);
    checkOutput("addi_retired3", oRetired, 32'd3);
    applyStimulus({12'h010, 5'd2, 3'b010, 5'd3, 7'b0000011}, 2, 4, 0);
    applyStimulus({7'h00, 5'd4, 5'd2, 3'b010, 5'd8, 7'b0100011}, 2, 4, 0);
    applyStimulus({7'h00, 5'd4, 5'd2, 3'b010, 5'd8, 7'b0100011}, 2, 0, 0);
    applyStimulus({7'h00, 5'd2, 5'd1, 3'b000, 5'd8, 7'b1100011}, 1, 0, 0);
    applyStimulus({7'h00, 5'd2, 5'd1, 3'b001, 5'd8, 7'b1100011}, 1, 0, 0);
    applyStimulus({7'h00, 5'd2, 5'd1, 3'b001, 5'd8, 7'b1100011}, 0, 0, 0);
    applyStimulus({7'h00, 5'd2, 5'd1, 3'b000, 5'd8, 7'b1100011}, 0, 0, 0);
    applyStimulus(32'h00500093, 2, 0, 0);
    applyStimulus(32'h0000007F, 2, 0, 0);
    applyStimulus(32'h00500093, 2, 0, 0);
    applyStimulus({12'h010, 5'd2, 3'b010, 5'd3, 7'b0000011}, 2, 0, 2);
    applyStimulus({7'b0100000, 5'd3, 5'd1, 3'b101, 5'd2, 7'b0010011}, 2, 0, 0);
    applyReset();
    for (int i = 0; i < 17; i++) applyStimulus(genLegal(), 2, $urandom_range(1, 4), 0);
    checkOutput("wrap_retired", oRetired, 32'd1);
    for (int i = 0; i < 60; i++) begin
      w = ($urandom_range(0, 9) == 0) ? genIllegal() : genLegal();
      applyStimulus(w, 2, $urandom_range(0, 6), 0);
    end

    // Configuration B: SKIP_MEM=0, MEM_TIMEOUT=0, CNT_W=32.
    rstA = 1'b1;
    sel = 1'b1; mSkip = 0; mTimeout = 0; mMask = 32'hFFFFFFFF;
    applyReset();
    applyStimulus({7'h00, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011}, 2, 0, 0);
    applyStimulus({12'h010, 5'd2, 3'b010, 5'd3, 7'b0000011}, 2, 4, 0);
    applyStimulus({12'h010, 5'd2, 3'b010, 5'd3, 7'b0000011}, 2, 20, 0);
    applyStimulus({7'h00, 5'd4, 5'd2, 3'b010, 5'd8, 7'b0100011}, 2, 1, 0);
    for (int i = 0; i < 40; i++) begin
      w = ($urandom_range(0, 9) == 0) ? genIllegal() : genLegal();
      applyStimulus(w, 2, $urandom_range(1, 8), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
